// File: rtl/pipeline_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
// The state enum doubles as the occupancy count (EMPTY=0, ONE=1, TWO=2).
package pipeline_pkg;

  localparam int DATA_W_DEF = 76;
  localparam int CTRL_W_DEF = 4;

  // MEM/WB bundle layout: {ctrl[4], wb_addr[4], upd_addr[4], data1[32], data2[32]}
  localparam int CTRL_LSB     = 72;
  localparam int WB_ADDR_LSB  = 68;
  localparam int UPD_ADDR_LSB = 64;
  localparam int DATA1_LSB    = 32;
  localparam int DATA2_LSB    = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  function automatic logic [DATA_W_DEF-1:0] mem_wb_pack(
    input logic [3:0]  ctrl,
    input logic [3:0]  wb_addr,
    input logic [3:0]  upd_addr,
    input logic [31:0] data1,
    input logic [31:0] data2
  );
    logic [DATA_W_DEF-1:0] word;
    word = '0;
    word[CTRL_LSB     +: 4]  = ctrl;
    word[WB_ADDR_LSB  +: 4]  = wb_addr;
    word[UPD_ADDR_LSB +: 4]  = upd_addr;
    word[DATA1_LSB    +: 32] = data1;
    word[DATA2_LSB    +: 32] = data2;
    return word;
  endfunction

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary.
// slave = the stage register itself, master = whatever drives and drains it.
interface pipeline_stage_reg_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipeline_stage_reg.sv
// One-cycle pipeline stage register with flush; define PIPELINE_STAGE_SKID_EN
// for the two-slot skid version with a registered in_ready.
//
// state    | meaning
// ---------+---------------------------------------
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | main slot holds the oldest entry
// ST_TWO   | main and skid slots full (skid build only)
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  pipeline_stage_reg_if.slave  bus
);

  stage_state_t      state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              rdy_q, rdy_nxt;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, move_skid;

  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.occupancy = state;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  // rdy_q is low through reset and rises on the first edge after release.
`ifdef PIPELINE_STAGE_SKID_EN
  assign bus.in_ready = rdy_q;
  assign rdy_nxt      = (state_nxt != ST_TWO);
`else
  assign bus.in_ready = rdy_q & (~bus.out_valid | bus.out_ready);
  assign rdy_nxt      = 1'b1;
`endif

  // Bubbles present an all-zero word, so the control field reads as a no-op.
  assign bus.out_data = {
    bus.out_valid ? main_q[DATA_W-1 -: CTRL_W]   : {CTRL_W{1'b0}},
    bus.out_valid ? main_q[DATA_W-CTRL_W-1:0]    : {(DATA_W-CTRL_W){1'b0}}
  };

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
`ifdef PIPELINE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_nxt = ST_TWO;
            load_skid = 1'b1;
`endif
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_nxt = ST_ONE;
            move_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_EMPTY;
      rdy_q  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= rdy_nxt;
      if (load_main)      main_q <= bus.in_data;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Randomized self-checking bench for pipeline_stage_reg against a queue model;
// covers both the single-slot build and the PIPELINE_STAGE_SKID_EN build.
module tb_pipeline_stage_reg;
  import pipeline_pkg::*;

  localparam int DW = 76;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  pipeline_stage_reg_if #(.DATA_W(DW)) bus ();

  pipeline_stage_reg #(.DATA_W(DW), .CTRL_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  logic [DW-1:0] q[$];
  logic [DW-1:0] in_log[$];
  logic [DW-1:0] out_log[$];
  bit            alive;
  bit            logging;
  int            total;
  int            bad;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    if (!alive) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || (bus.out_ready == 1'b1);
  endfunction

  task automatic check_model();
    logic [DW-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : '0;
    chk("occupancy", DW'(bus.occupancy), DW'(q.size()));
    chk("out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
    chk("out_data",  bus.out_data, exp_data);
    chk("in_ready",  DW'(bus.in_ready), DW'(exp_rdy()));
    if (SKID && alive) begin
      bus.out_ready = ~bus.out_ready;
      #1;
      chk("in_ready_vs_out_ready", DW'(bus.in_ready), DW'(exp_rdy()));
      bus.out_ready = ~bus.out_ready;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit in_f, out_f;
    @(negedge clock);
    check_model();
    in_f  = bus.in_valid && exp_rdy();
    out_f = (q.size() > 0) && bus.out_ready;
    @(posedge clock);
    if (flush) begin
      q.delete();
    end else begin
      if (out_f) begin
        if (logging) out_log.push_back(q[0]);
        void'(q.pop_front());
      end
      if (in_f) begin
        q.push_back(bus.in_data);
        if (logging) in_log.push_back(bus.in_data);
      end
    end
    alive = 1'b1;
    #1;
  endtask

  initial begin
    logic [95:0]   rnd;
    logic [DW-1:0] word_a, word_b, word_c;
    total = 0;
    bad   = 0;
    alive = 1'b0;
    logging = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", DW'(bus.out_valid), '0);
    chk("rst_out_data",  bus.out_data, '0);
    chk("rst_occupancy", DW'(bus.occupancy), '0);
    chk("rst_in_ready",  DW'(bus.in_ready), '0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    chk("in_ready_after_release", DW'(bus.in_ready), DW'(1));

    // single MEM/WB write
    bus.in_data   = 76'hA49_10293847_00001111;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single_out_valid", DW'(bus.out_valid), DW'(1));
    chk("single_out_data",  bus.out_data, 76'hA49_10293847_00001111);
    chk("single_occupancy", DW'(bus.occupancy), DW'(1));

`ifndef PIPELINE_STAGE_SKID_EN
    // stalled single slot, then replacement with no bubble
    bus.out_ready = 1'b0;
    #1 chk("stall_in_ready", DW'(bus.in_ready), DW'(0));
    bus.out_ready = 1'b1;
    #1 chk("release_in_ready", DW'(bus.in_ready), DW'(1));
    bus.in_data  = 76'h5_3C_0000BEEF_CAFE0001;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("replace_out_valid", DW'(bus.out_valid), DW'(1));
    chk("replace_out_data",  bus.out_data, 76'h5_3C_0000BEEF_CAFE0001);
    chk("replace_occupancy", DW'(bus.occupancy), DW'(1));
`endif

    bus.out_ready = 1'b1;
    repeat (3) step();

`ifdef PIPELINE_STAGE_SKID_EN
    // backpressure fills both slots, then drains A then B
    word_a = 76'h1_11_11111111_AAAAAAAA;
    word_b = 76'h2_22_22222222_BBBBBBBB;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = word_a;
    step();
    bus.in_data = word_b;
    step();
    bus.in_valid = 1'b0;
    chk("bp_occupancy", DW'(bus.occupancy), DW'(2));
    chk("bp_in_ready",  DW'(bus.in_ready), DW'(0));
    chk("bp_head_a",    bus.out_data, word_a);
    bus.out_ready = 1'b1;
    step();
    chk("bp_then_b", bus.out_data, word_b);
    step();
    chk("bp_drained", DW'(bus.out_valid), DW'(0));
`endif

    // flush with the stage full and a new word offered
    word_c = 76'hC_CC_CCCCCCCC_CCCCCCCC;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      bus.in_data = DW'(i + 76'h7_00_00000000_00000100);
      step();
    end
    bus.in_data = word_c;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_occupancy", DW'(bus.occupancy), '0);
    chk("flush_out_valid", DW'(bus.out_valid), '0);
    chk("flush_out_data",  bus.out_data, '0);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // 100 incrementing words under random backpressure
    logging = 1'b1;
    for (int cyc = 0; cyc < 3000 && in_log.size() < 100; cyc++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = DW'(in_log.size());
      bus.out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    logging = 1'b0;
    chk("stream_in_count",  DW'(in_log.size()), DW'(100));
    chk("stream_out_count", DW'(out_log.size()), DW'(100));
    for (int i = 0; i < 100 && i < out_log.size(); i++)
      chk("stream_order", out_log[i], DW'(i));

    // random traffic with occasional flush
    for (int cyc = 0; cyc < 400; cyc++) begin
      rnd = {$urandom, $urandom, $urandom};
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = rnd[DW-1:0];
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // asynchronous reset while full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (CAP + 1) begin
      bus.in_data = {$urandom, $urandom, $urandom};
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_reset_occupancy", DW'(bus.occupancy), DW'(CAP));
    #1 reset = 1'b1;
    #1;
    chk("async_out_valid", DW'(bus.out_valid), '0);
    chk("async_out_data",  bus.out_data, '0);
    chk("async_occupancy", DW'(bus.occupancy), '0);
    chk("async_in_ready",  DW'(bus.in_ready), '0);
    q.delete();
    alive = 1'b0;
    #1 reset = 1'b0;
    step();
    chk("post_reset_in_ready",  DW'(bus.in_ready), DW'(1));
    chk("post_reset_occupancy", DW'(bus.occupancy), '0);
    bus.out_ready = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
